// File: rtl/ras_predictor.sv
// Return address stack predictor: pushes link addresses on RV32I calls, pops them on returns.
// Define RAS_STATS_EN to enable the saturating overflow/underflow event counters.
module ras_predictor #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_inst,
   input  logic [31:0]      fetch_PC,
   input  logic             squash,
   output logic             pred_valid,
   output logic [31:0]      pred_target,
   output logic             ras_empty,
   output logic             ras_full,
   output logic [CNT_W-1:0] ovf_cnt,
   output logic [CNT_W-1:0] unf_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic [31:0]   stack_q [DEPTH];
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pred_valid_q, pred_valid_d;
   logic [31:0]   pred_target_q, pred_target_d;

   logic          wr_en;
   logic [PW-1:0] wr_idx;
   logic [31:0]   wr_data;
   logic [PW-1:0] top_idx;

   logic [6:0]    opcode;
   logic [4:0]    rd;
   logic [4:0]    rs1;
   logic          is_jal, is_jalr, rd_link, rs1_link;
   logic          push_only, pop_only, replace;
   logic          unused_inst_bits;

   assign opcode   = fetch_inst[6:0];
   assign rd       = fetch_inst[11:7];
   assign rs1      = fetch_inst[19:15];
   assign unused_inst_bits = ^{fetch_inst[31:20], fetch_inst[14:12]};

   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
   assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

   // Operations are mutually exclusive and already qualified by valid fetch and no squash.
   assign replace   = fetch_valid && !squash && is_jalr && rd_link && rs1_link && (rd != rs1);
   assign push_only = fetch_valid && !squash && (is_jal || is_jalr) && rd_link && !replace;
   assign pop_only  = fetch_valid && !squash && is_jalr && rs1_link && !rd_link;

   assign top_idx   = ptr_q - PTR_ONE;
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_MAX);

   always_comb begin
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      pred_valid_d  = 1'b0;
      pred_target_d = pred_target_q;
      wr_en         = 1'b0;
      wr_idx        = ptr_q;
      wr_data       = fetch_PC + 32'd4;

      if (squash) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (replace) begin
         wr_en = 1'b1;
         if (!ras_empty) begin
            wr_idx        = top_idx;
            pred_valid_d  = 1'b1;
            pred_target_d = stack_q[top_idx];
         end else begin
            ptr_d = ptr_q + PTR_ONE;
            cnt_d = CNT_ONE;
         end
      end else if (push_only) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + PTR_ONE;
         if (!ras_full) cnt_d = cnt_q + CNT_ONE;
      end else if (pop_only && !ras_empty) begin
         pred_valid_d  = 1'b1;
         pred_target_d = stack_q[top_idx];
         ptr_d         = top_idx;
         cnt_d         = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         cnt_q         <= '0;
         pred_valid_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         pred_valid_q  <= pred_valid_d;
         pred_target_q <= pred_target_d;
      end
   end

   // Entry storage carries no reset; the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) stack_q[wr_idx] <= wr_data;
   end

   assign pred_valid  = pred_valid_q;
   assign pred_target = pred_target_q;

`ifdef RAS_STATS_EN
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;
   logic             ovf_evt, unf_evt;

   assign ovf_evt = push_only && ras_full;
   assign unf_evt = (pop_only || replace) && ras_empty;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      unf_cnt_d = unf_cnt_q;
      if (ovf_evt && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (unf_evt && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
         unf_cnt_q <= unf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
   assign unf_cnt = unf_cnt_q;
`else
   assign ovf_cnt = '0;
   assign unf_cnt = '0;
`endif

endmodule

// File: doc/ras_predictor.md
RAS_PREDICTOR -- requirements
Module: ras_predictor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, stack entries (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fetch_valid  input  1  fetch_inst/fetch_PC qualify this cycle.
REQ-006 fetch_inst  input  32  RV32I instruction word being fetched.
REQ-007 fetch_PC  input  32  address of fetch_inst.
REQ-008 squash  input  1  pipeline flush; empties the stack.
REQ-009 pred_valid  output  1  registered; pred_target is a valid return prediction.
REQ-010 pred_target  output  32  registered predicted return address.
REQ-011 ras_empty  output  1  count == 0.
REQ-012 ras_full  output  1  count == DEPTH.
REQ-013 ovf_cnt  output  CNT_W  overflow event count (see Configuration).
REQ-014 unf_cnt  output  CNT_W  underflow event count (see Configuration).

Function
REQ-015 Decode only when fetch_valid=1: opcode=inst[6:0], rd=inst[11:7], rs1=inst[19:15]; link register = x1 or x5.
REQ-016 Push: JAL (1101111) or JALR (1100111) with rd a link register; value pushed = fetch_PC + 4, modulo 2^32.
REQ-017 Pop: JALR with rs1 a link register and rd not a link register.
REQ-018 JALR with rd and rs1 both link and rd != rs1: pop then push in one cycle; top entry replaced by fetch_PC+4, count unchanged.
REQ-019 JALR with rd == rs1, both link: push only.
REQ-020 Non-jump instructions and JAL/JALR without link registers: no state change; pred_valid=0 next cycle.
REQ-021 Stack is circular: top pointer (log2 DEPTH bits) wraps modulo DEPTH; count saturates at DEPTH.
REQ-022 Push when full: oldest entry overwritten, pointer advances, count stays DEPTH, overflow event.
REQ-023 Pop when empty: pointer and count unchanged, pred_valid=0 next cycle, underflow event.
REQ-024 Latency: a successful pop at cycle N drives pred_valid=1 and pred_target=popped entry during cycle N+1 only (one-cycle pulse).
REQ-025 Pop with replace (REQ-018) drives pred_target = entry popped before the push.
REQ-026 squash=1 has priority over a simultaneous fetch: count=0, pointer=0, pred_valid=0 next cycle; entry contents need not be cleared.
REQ-027 ras_empty/ras_full are combinational from the registered count.

Reset
REQ-028 On rst_n=0, asynchronously: count=0, pointer=0, pred_valid=0, pred_target=0, ovf_cnt=0, unf_cnt=0.
REQ-029 Reset mid-operation discards all stack contents; first fetch after release sees an empty stack.
REQ-030 Entry storage does not require reset.

Configuration
REQ-031 Macro RAS_STATS_EN defined: ovf_cnt increments on each overflow event, unf_cnt on each underflow event, both saturating at 2^CNT_W-1, unaffected by squash.
REQ-032 RAS_STATS_EN undefined: no counter logic; ovf_cnt and unf_cnt tied to 0; ports still present.

Verification
REQ-033 JAL x1 at PC 0x100, then JALR x0,0(x1) -> cycle after JALR: pred_valid=1, pred_target=0x104, ras_empty=1.
REQ-034 Nine JAL x1 at PCs 0x0,0x10..0x80 (DEPTH=8) then nine pops -> targets 0x84,0x74..0x14, ninth pop pred_valid=0; with RAS_STATS_EN ovf_cnt=1, unf_cnt=1.
REQ-035 JAL x1 at 0x200, then JALR x5,0(x1) at 0x300 -> pred_target=0x204, top now 0x304, count stays 1.
REQ-036 JAL x1 at 0x400 and squash=1 same cycle -> ras_empty=1; following JALR x0,0(x1) gives pred_valid=0.
REQ-037 Two JAL x1 pushes, assert rst_n=0 between clock edges -> outputs zero immediately, ras_empty=1 after release.
REQ-038 JAL x1 at 0xFFFFFFFC then pop -> pred_target=0x00000000 (wrap).
